// File: rtl/rng_pkg.sv
// Shared constants, FSM state type and the xorshift128 step function for the RNG server.
package rng_pkg;

  localparam logic [31:0] RNG_SEED_X = 32'd123456789;
  localparam logic [31:0] RNG_SEED_Y = 32'd362436069;
  localparam logic [31:0] RNG_SEED_Z = 32'd521288629;
  localparam logic [31:0] RNG_SEED_W = 32'd88675123;
  localparam logic [127:0] RNG_SEED = {RNG_SEED_X, RNG_SEED_Y, RNG_SEED_Z, RNG_SEED_W};

  typedef enum logic {ST_WARMUP, ST_SERVE} rng_state_t;

  // State packed as {x,y,z,w}; returns {y,z,w,w'} where w' is the freshly produced word.
  function automatic logic [127:0] xs128_next(input logic [127:0] s);
    logic [31:0] x, y, z, w, t, nw;
    x  = s[127:96];
    y  = s[95:64];
    z  = s[63:32];
    w  = s[31:0];
    t  = x ^ (x << 11);
    nw = w ^ (w >> 19) ^ t ^ (t >> 8);
    return {y, z, w, nw};
  endfunction

endpackage

// File: rtl/xs128_core.sv
// xorshift128 state registers: reset seeds on rst, parallel load, or one step per enable.
module xs128_core
  import rng_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  input  logic         load,
  input  logic [127:0] load_val,
  output logic [31:0]  w
);

  logic [127:0] s;

  always_ff @(posedge clk) begin
    if (rst)       s <= RNG_SEED;
    else if (load) s <= load_val;
    else if (step) s <= xs128_next(s);
  end

  assign w = s[31:0];

endmodule

// File: rtl/rng_rr_server.sv
// Round-robin server sharing one xorshift128 generator among N_REQ requesters.
// Optional reseed port pair enabled by defining RNG_SEED_LOAD_EN.
module rng_rr_server
  import rng_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int WARMUP = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             rnd_valid,
  output logic [31:0]      rnd_data,
  output logic             busy
`ifdef RNG_SEED_LOAD_EN
  ,
  input  logic             seed_load,
  input  logic [127:0]     seed_data
`endif
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam rng_state_t ST_RST = (WARMUP == 0) ? ST_SERVE : ST_WARMUP;

  rng_state_t     state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [PW-1:0]  ptr, sel;
  logic           found, step, grant_en, reseed;
  logic [127:0]   load_val;
  logic [31:0]    w;
  int             idx;

`ifdef RNG_SEED_LOAD_EN
  // An all-zero seed would lock xorshift at zero forever, so substitute the reset seeds.
  assign reseed   = seed_load;
  assign load_val = (seed_data == '0) ? RNG_SEED : seed_data;
`else
  assign reseed   = 1'b0;
  assign load_val = RNG_SEED;
`endif

  xs128_core u_core (
    .clk      (clk),
    .rst      (rst),
    .step     (step),
    .load     (reseed),
    .load_val (load_val),
    .w        (w)
  );

  // First requesting index at or above ptr, wrapping around.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    step     = 1'b0;
    grant_en = 1'b0;
    if (reseed) begin
      cnt_n   = CW'(WARMUP);
      state_n = ST_RST;
    end else begin
      case (state)
        ST_WARMUP: begin
          if (cnt == '0) begin
            state_n = ST_SERVE;
          end else begin
            step  = 1'b1;
            cnt_n = cnt - 1'b1;
            if (cnt == CW'(1)) state_n = ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (found) begin
            step     = 1'b1;
            grant_en = 1'b1;
          end
        end
        default: state_n = ST_RST;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RST;
      cnt       <= CW'(WARMUP);
      ptr       <= '0;
      gnt       <= '0;
      rnd_valid <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rnd_valid <= grant_en;
      gnt       <= '0;
      if (grant_en) begin
        gnt[sel] <= 1'b1;
        ptr      <= (int'(sel) == N_REQ - 1) ? '0 : sel + 1'b1;
      end
    end
  end

  // The core's w already holds the stepped word in the cycle after a grant.
  assign rnd_data = rnd_valid ? w : 32'd0;
  assign busy     = (state == ST_WARMUP);

endmodule
